// File: rtl/mvm_seq_pkg.sv
// rtl/mvm_seq_pkg.sv - shared types and width helpers for the MVM stream sequencer
package mvm_seq_pkg;

  localparam int K_DEF       = 8;
  localparam int B_DEF       = 12;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [3:0] {
    IDLE,
    FILL_M,
    LOAD_M,
    FILL_V,
    LOAD_V,
    WAIT_SPACE,
    START,
    WAIT_DONE,
    CAPTURE
  } state_t;

  // FIFO occupancy width: storage depth plus the registered output slot.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - synchronous FIFO with a registered output slot
module seq_fifo
  import mvm_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [W-1:0]                      wdata,
  input  logic                              pop,
  output logic [W-1:0]                      rdata,
  output logic                              full,
  output logic                              empty,
  output logic [fifo_cnt_width(DEPTH)-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = fifo_cnt_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] scount;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          push_ok, pop_ok, load_out;

  assign full     = (scount == CW'(DEPTH));
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & out_valid;
  // Refill the output slot whenever it is free or being consumed this cycle.
  assign load_out = (scount != '0) & (~out_valid | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      scount    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (load_out) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop_ok) begin
        out_valid <= 1'b0;
      end
      scount <= scount + CW'(push_ok) - CW'(load_out);
    end
  end

  assign rdata = out_data;
  assign empty = ~out_valid;
  assign count = scount + CW'(out_valid);

endmodule

// File: rtl/mvm_stream_sequencer.sv
// rtl/mvm_stream_sequencer.sv - stream front end that feeds and drains a non-stallable MVM core
module mvm_stream_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int B       = B_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_new_matrix,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [B-1:0]   s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [2*B-1:0] m_data,
  output logic           m_last,
  output logic           core_load_matrix,
  output logic           core_load_vector,
  output logic           core_start,
  output logic [B-1:0]   core_data,
  input  logic           core_done,
  input  logic [2*B-1:0] core_result,
  output logic           busy,
  output logic           err_nomatrix,
  output logic           err_timeout
);

  localparam int NMAT = K * K;
  localparam int RW   = 2 * B;
  localparam int CW   = $clog2(NMAT + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int IW   = fifo_cnt_width(NMAT);
  localparam int OW   = fifo_cnt_width(K);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          mat_valid;
  logic          cnt_inc, set_mat, set_nomat, timeout_hit, cap_last;

  logic          ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
  logic [B-1:0]  ibuf_rdata;
  logic [IW-1:0] ibuf_count;
  logic          obuf_push, obuf_full, obuf_empty;
  logic [RW:0]   obuf_rdata;
  logic [OW-1:0] obuf_count;

  seq_fifo #(.W(B), .DEPTH(NMAT)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (ibuf_push),
    .wdata (s_data),
    .pop   (ibuf_pop),
    .rdata (ibuf_rdata),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  seq_fifo #(.W(RW + 1), .DEPTH(K)) u_obuf (
    .clk   (clk),
    .reset (reset),
    .push  (obuf_push),
    .wdata ({cap_last, core_result}),
    .pop   (m_ready),
    .rdata (obuf_rdata),
    .full  (obuf_full),
    .empty (obuf_empty),
    .count (obuf_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    cmd_ready        = 1'b0;
    s_ready          = 1'b0;
    ibuf_push        = 1'b0;
    ibuf_pop         = 1'b0;
    obuf_push        = 1'b0;
    cap_last         = 1'b0;
    core_load_matrix = 1'b0;
    core_load_vector = 1'b0;
    core_start       = 1'b0;
    core_data        = '0;
    cnt_inc          = 1'b0;
    set_mat          = 1'b0;
    set_nomat        = 1'b0;
    timeout_hit      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid) begin
          set_nomat = ~cmd_new_matrix & ~mat_valid;
          state_nx  = (cmd_new_matrix | ~mat_valid) ? FILL_M : FILL_V;
        end
      end
      // ibuf is empty on entry to either fill state, so its count is the word count.
      FILL_M: begin
        s_ready   = ~ibuf_full;
        ibuf_push = s_valid & ~ibuf_full;
        if (ibuf_push && ibuf_count == IW'(NMAT - 1)) state_nx = LOAD_M;
      end
      LOAD_M: begin
        cnt_inc = 1'b1;
        if (cnt == '0) begin
          core_load_matrix = 1'b1;
        end else begin
          ibuf_pop  = ~ibuf_empty;
          core_data = ibuf_rdata;
        end
        if (cnt == CW'(NMAT)) begin
          set_mat  = 1'b1;
          state_nx = FILL_V;
        end
      end
      FILL_V: begin
        s_ready   = ~ibuf_full;
        ibuf_push = s_valid & ~ibuf_full;
        if (ibuf_push && ibuf_count == IW'(K - 1)) state_nx = LOAD_V;
      end
      LOAD_V: begin
        cnt_inc = 1'b1;
        if (cnt == '0) begin
          core_load_vector = 1'b1;
        end else begin
          ibuf_pop  = ~ibuf_empty;
          core_data = ibuf_rdata;
        end
        if (cnt == CW'(K)) state_nx = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (obuf_count == '0) state_nx = START;
      end
      START: begin
        core_start = 1'b1;
        state_nx   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done) begin
          state_nx = CAPTURE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end
      end
      CAPTURE: begin
        obuf_push = ~obuf_full;
        cnt_inc   = 1'b1;
        if (cnt == CW'(K - 1)) begin
          cap_last = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != state_nx) cnt <= '0;
    else if (cnt_inc)               cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mat_valid    <= 1'b0;
      err_nomatrix <= 1'b0;
      err_timeout  <= 1'b0;
      timer        <= '0;
    end else begin
      if (set_nomat)   err_nomatrix <= 1'b1;
      if (timeout_hit) err_timeout  <= 1'b1;
      if (set_mat)          mat_valid <= 1'b1;
      else if (timeout_hit) mat_valid <= 1'b0;
      if (state == START)
        timer <= '0;
      else if (state == WAIT_DONE && timer != TW'(TIMEOUT))
        timer <= timer + 1'b1;
    end
  end

  assign m_valid = ~obuf_empty;
  assign m_data  = obuf_rdata[RW-1:0];
  assign m_last  = obuf_rdata[RW];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mvm_stream_sequencer.sv
// tb/tb_mvm_stream_sequencer.sv - directed self-checking bench with a behavioural MVM core
module tb_mvm_stream_sequencer;

  localparam int K  = 8;
  localparam int B  = 12;
  localparam int RW = 24;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_new_matrix = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [B-1:0]  s_data = '0;
  logic          m_valid, m_ready = 1'b1, m_last;
  logic [RW-1:0] m_data;
  logic          core_load_matrix, core_load_vector, core_start, core_done = 1'b0;
  logic [B-1:0]  core_data;
  logic [RW-1:0] core_result = '0;
  logic          busy, err_nomatrix, err_timeout;
  logic [9:0]    ctl;

  always #5 clk = ~clk;

  mvm_stream_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_new_matrix   (cmd_new_matrix),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .core_load_matrix (core_load_matrix),
    .core_load_vector (core_load_vector),
    .core_start       (core_start),
    .core_data        (core_data),
    .core_done        (core_done),
    .core_result      (core_result),
    .busy             (busy),
    .err_nomatrix     (err_nomatrix),
    .err_timeout      (err_timeout)
  );

  assign ctl = {cmd_ready, s_ready, m_valid, m_last, core_load_matrix, core_load_vector,
                core_start, busy, err_nomatrix, err_timeout};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural core: captures load windows, computes A*x, answers done after done_delay.
  logic signed [B-1:0]  mdl_mat [N];
  logic signed [B-1:0]  mdl_vec [K];
  logic signed [RW-1:0] mdl_y   [K];
  logic signed [RW-1:0] acc;
  int mdl_mode = 0, mdl_idx = 0, mdl_dly = 0;
  int n_lm = 0, n_lv = 0, n_st = 0;
  int done_delay = 5;
  bit done_en = 1'b1;
  bit stray_done = 1'b0;

  always @(negedge clk) begin
    core_done = stray_done;
    if (reset) begin
      mdl_mode    = 0;
      core_result = '0;
    end else begin
      if (core_load_matrix) n_lm++;
      if (core_load_vector) n_lv++;
      if (core_start)       n_st++;
      case (mdl_mode)
        0: begin
          core_result = 24'h5A5A5A;
          if (core_load_matrix)      begin mdl_mode = 1; mdl_idx = 0; end
          else if (core_load_vector) begin mdl_mode = 2; mdl_idx = 0; end
          else if (core_start) begin
            mdl_mode = 3;
            mdl_dly  = 0;
            for (int i = 0; i < K; i++) begin
              acc = '0;
              for (int j = 0; j < K; j++) acc = acc + mdl_mat[i*K+j] * mdl_vec[j];
              mdl_y[i] = acc;
            end
          end
        end
        1: begin mdl_mat[mdl_idx] = core_data; mdl_idx++; if (mdl_idx == N) mdl_mode = 0; end
        2: begin mdl_vec[mdl_idx] = core_data; mdl_idx++; if (mdl_idx == K) mdl_mode = 0; end
        3: begin
          mdl_dly++;
          if (done_en && mdl_dly >= done_delay) begin core_done = 1'b1; mdl_mode = 4; mdl_idx = 0; end
        end
        default: begin
          core_result = mdl_y[mdl_idx];
          mdl_idx++;
          if (mdl_idx == K) mdl_mode = 0;
        end
      endcase
    end
  end

  logic [RW-1:0] res_d [$];
  logic          res_l [$];

  always @(negedge clk) begin
    #1;
    if (!reset && m_valid && m_ready) begin
      res_d.push_back(m_data);
      res_l.push_back(m_last);
    end
  end

  logic [B-1:0]  mat_q [$];
  logic [B-1:0]  vec_q [$];
  logic [RW-1:0] exp_q [$];
  int lm0, lv0, st0, g;

  task automatic send_cmd(input logic nm);
    int gc = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_new_matrix = nm;
    #1;
    while (!cmd_ready && gc < 3000) begin @(negedge clk); #1; gc++; end
    chk("cmd_ready_seen", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input logic [B-1:0] w [$], input bit gaps);
    int i = 0, gw = 0;
    bit v;
    while (i < w.size() && gw < 3000) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = v ? w[i] : 12'hFFF;
      #1;
      if (v && s_ready) i++;
      gw++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("words_accepted", i, w.size());
  endtask

  task automatic check_results(input string tag);
    int gr = 0;
    while (res_d.size() < exp_q.size() && gr < 3000) begin @(negedge clk); gr++; end
    chk({tag, "_count"}, res_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < res_d.size(); i++) begin
      chk({tag, "_y"}, res_d[i], exp_q[i]);
      chk({tag, "_last"}, res_l[i], (i % K) == K - 1);
    end
    res_d.delete();
    res_l.delete();
  endtask

  function automatic int core_bad(input bit with_mat);
    int bad = 0;
    if (with_mat) for (int i = 0; i < N; i++) if (mdl_mat[i] !== mat_q[i]) bad++;
    for (int i = 0; i < K; i++) if (mdl_vec[i] !== vec_q[i]) bad++;
    return bad;
  endfunction

  task automatic snap();
    lm0 = n_lm; lv0 = n_lv; st0 = n_st;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", ctl, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_m_data", m_data, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // 1: identity matrix, x = 1..8, no gaps
    mat_q.delete(); vec_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) mat_q.push_back((i / K == i % K) ? 12'd1 : 12'd0);
    for (int i = 0; i < K; i++) begin vec_q.push_back(12'(i + 1)); exp_q.push_back(24'(i + 1)); end
    snap();
    send_cmd(1'b1);
    chk("t1_busy", busy, 1);
    send_words(mat_q, 1'b0);
    send_words(vec_q, 1'b0);
    check_results("t1");
    chk("t1_n_lm", n_lm - lm0, 1);
    chk("t1_n_lv", n_lv - lv0, 1);
    chk("t1_n_st", n_st - st0, 1);
    chk("t1_core_words", core_bad(1'b1), 0);
    chk("t1_err_nomatrix", err_nomatrix, 0);

    // 2: reuse matrix, x = all 2
    vec_q.delete(); exp_q.delete();
    for (int i = 0; i < K; i++) begin vec_q.push_back(12'd2); exp_q.push_back(24'd2); end
    snap();
    send_cmd(1'b0);
    send_words(vec_q, 1'b0);
    check_results("t2");
    chk("t2_n_lm", n_lm - lm0, 0);
    chk("t2_n_st", n_st - st0, 1);

    // 3: A(i,j) = i+j with random s_valid gaps, x = 1s
    mat_q.delete(); vec_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) mat_q.push_back(12'(i / K + i % K));
    for (int i = 0; i < K; i++) begin vec_q.push_back(12'd1); exp_q.push_back(24'(8 * i + 28)); end
    snap();
    send_cmd(1'b1);
    send_words(mat_q, 1'b1);
    send_words(vec_q, 1'b1);
    check_results("t3");
    chk("t3_core_words", core_bad(1'b1), 0);
    chk("t3_n_lm", n_lm - lm0, 1);

    // 4: results held back; next start must wait for obuf to drain
    @(negedge clk);
    m_ready = 1'b0;
    send_cmd(1'b0);
    send_words(vec_q, 1'b0);
    repeat (60) @(negedge clk);
    chk("t4_m_valid", m_valid, 1);
    chk("t4_hold_data", m_data, 28);
    vec_q.delete();
    for (int i = 0; i < K; i++) vec_q.push_back(12'd2);
    snap();
    send_cmd(1'b0);
    send_words(vec_q, 1'b0);
    repeat (60) @(negedge clk);
    chk("t4_start_held", n_st - st0, 0);
    chk("t4_busy", busy, 1);
    chk("t4_hold_data2", m_data, 28);
    m_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < K; i++) exp_q.push_back(24'(8 * i + 28));
    for (int i = 0; i < K; i++) exp_q.push_back(24'(16 * i + 56));
    check_results("t4");
    chk("t4_n_st", n_st - st0, 1);

    // 5: reuse command straight after reset falls back to a full load
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    mat_q.delete(); vec_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) mat_q.push_back((i / K == i % K) ? 12'd1 : 12'd0);
    for (int i = 0; i < K; i++) begin vec_q.push_back(12'(-(i + 1))); exp_q.push_back(24'(-(i + 1))); end
    snap();
    send_cmd(1'b0);
    chk("t5_err_nomatrix", err_nomatrix, 1);
    send_words(mat_q, 1'b0);
    send_words(vec_q, 1'b0);
    check_results("t5");
    chk("t5_n_lm", n_lm - lm0, 1);

    // 6a: core never answers
    done_en = 1'b0;
    vec_q.delete();
    for (int i = 0; i < K; i++) vec_q.push_back(12'd1);
    snap();
    send_cmd(1'b0);
    send_words(vec_q, 1'b0);
    g = 0;
    while (n_st == st0 && g < 500) begin @(negedge clk); g++; end
    chk("t6_started", n_st - st0, 1);
    repeat (250) @(negedge clk);
    chk("t6_err_early", err_timeout, 0);
    chk("t6_busy_early", busy, 1);
    repeat (10) @(negedge clk);
    chk("t6_err_timeout", err_timeout, 1);
    chk("t6_busy", busy, 0);

    // 6b: reset in the middle of LOAD_M
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_en = 1'b1;
    chk("t6_err_cleared", {err_nomatrix, err_timeout}, 0);
    snap();
    send_cmd(1'b1);
    send_words(mat_q, 1'b0);
    g = 0;
    while (n_lm == lm0 && g < 100) begin @(negedge clk); g++; end
    chk("t6_load_seen", n_lm - lm0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t6_abort_ctl", ctl, 0);
    chk("t6_abort_core_data", core_data, 0);
    reset = 1'b0;
    snap();
    stray_done = 1'b1;
    repeat (3) @(negedge clk);
    stray_done = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_no_pulses", (n_lm - lm0) + (n_lv - lv0) + (n_st - st0), 0);
    chk("t6_idle", {busy, m_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
